mul_seq_mac: RTL and testbench
==============================

Name: mul_seq_mac

Overview:
- Parametrised multi-cycle multiplier/MAC. Successor to the radix-2 signed shift-add multiplier.
- Adds configurable bits per cycle, unsigned/signed/mixed-sign modes, an optional accumulate addend, early termination on multiplier magnitude, and valid/ready handshakes on both sides.
- Sits beside the peripheral datapath as a shared arithmetic unit.

Parameters:
- WIDTH, 16, operand width in bits. Must be ≥4.
- BPC, 2, multiplier bits retired per cycle. Legal values are 1, 2 and 4; BPC must divide WIDTH (elaboration-time assertion).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  unit can accept operands.
- a_i  in  WIDTH  multiplicand.
- b_i  in  WIDTH  multiplier.
- c_i  in  2*WIDTH  addend, used only when acc_en_i=1.
- mode_i  in  2  00 unsigned×unsigned; 01 signed×signed; 10 signed a × unsigned b; 11 treated as 00.
- acc_en_i  in  1  add c_i to the product.
- flush_i  in  1  abort any operation.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  2*WIDTH  product (+c_i), modulo 2^(2*WIDTH).
- busy_o  out  1  high in CALC.

Behaviour:
- States are IDLE, CALC and DONE. Reset values: state=IDLE, out_valid_o=0, result_o=0, busy_o=0, all internal registers 0. in_ready_o is then 1.
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). It is combinational and does not depend on in_valid_i.
- Accept happens when in_valid_i & in_ready_o. At that edge, latch:
  - |a| into a 2W-bit multiplicand register, zero-extended;
  - |b| into a W-bit multiplier register;
  - neg = (a signed & a_i[MSB]) XOR (b signed & b_i[MSB]);
  - c_i if acc_en_i, else 0;
  - acc = 0.
  Then go to CALC.
- Magnitude of the most negative value: 2^(W-1), which fits W bits unsigned.
- CALC, one edge per chunk:
  - acc += mcand × mreg[BPC-1:0]; mcand <<= BPC; mreg >>= BPC.
  - The chunk is the last one if the shifted mreg is 0 or the chunk count reaches WIDTH/BPC.
  - On the last chunk, compute result_o <= (neg ? -acc_next : acc_next) + addend in the same edge, set out_valid_o=1, and go to DONE.
- Latency: out_valid_o rises K edges after the accept edge, where K = max(1, ceil(bitlen(|b|)/BPC)), with K ≤ WIDTH/BPC.
- DONE:
  - result_o and out_valid_o are held stable until out_ready_i.
  - On the handshake edge, if in_valid_i is also high, the new operands are accepted and the state goes straight to CALC (back-to-back, no bubble). Otherwise go to IDLE with out_valid_o=0.
- out_valid_o is only deasserted by handshake, flush or reset. result_o keeps its last value after the handshake.
- flush_i has priority over everything except rst. At the next edge: state=IDLE, out_valid_o=0, busy_o=0. The operand offered in the flush cycle is not accepted, and in_ready_o is forced to 0 during flush_i.
- rst mid-operation behaves as flush and also clears result_o to 0.
- Inputs presented outside an accept edge are ignored. Operands may change freely during CALC.
- Overflow of the accumulate wraps silently; no flag is produced.

Decomposition:
- Shared package mul_pkg holds:
  - mode enum: MUL_UU, MUL_SS, MUL_SU;
  - state enum: ST_IDLE, ST_CALC, ST_DONE;
  - localparam helpers: NCHUNK = WIDTH/BPC, and the counter width $clog2(NCHUNK+1).
- One sub-module, mul_pp: a combinational BPC-bit × 2W partial-product generator (mcand × chunk). It is instantiated once.

Test Plan:
- WIDTH=16, BPC=2, mode=01, a=0xFFFD (-3), b=0x0007 -> result 0xFFFFFFEB (-21); out_valid_o 2 cycles after accept.
- mode=01, a=0x8000, b=0x8000 -> 0x40000000 after 8 cycles. Also mode=00, a=b=0xFFFF -> 0xFFFE0001 after 8 cycles.
- mode=10, a=0xFFFF, b=0xFFFF -> 0xFFFF0001 (-65535). Same operands with mode=11 -> 0xFFFE0001.
- b=0, acc_en=1, c=0x12345678 -> 0x12345678 after 1 cycle. Then a=5, b=3, acc_en=1, c=0xFFFFFFF0 -> 0xFFFFFFFF.
- Backpressure and back-to-back: hold out_ready_i=0 for 5 cycles -> result_o and out_valid_o stable, in_ready_o=0. Then raise out_ready_i with in_valid_i=1 (a=2, b=3, mode=00) -> accepted same edge, next result 0x00000006 with no IDLE cycle.
- flush_i asserted on the 3rd CALC cycle of 0x8000×0x8000 -> IDLE next edge, no out_valid_o pulse. Repeat with rst instead -> same, plus result_o=0. A following operation completes correctly.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the sequential multiplier/MAC.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_UU = 2'b00,
        MUL_SS = 2'b01,
        MUL_SU = 2'b10
    } mul_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

    function automatic int mul_nchunk(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int mul_cnt_w(input int nchunk);
        return $clog2(nchunk + 1);
    endfunction

endpackage

// File: rtl/mul_pp.sv
// Combinational partial product: 2W-bit multiplicand times a BPC-bit chunk.
module mul_pp
    import mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BPC   = 2
) (
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [BPC-1:0]     chunk_i,
    output logic [2*WIDTH-1:0] pp_o
);

    // Sum of shifted multiplicand copies selected by the chunk bits
    always_comb begin
        pp_o = '0;
        for (int i = 0; i < BPC; i++) begin
            if (chunk_i[i]) begin
                pp_o = pp_o + (mcand_i << i);
            end else begin
                pp_o = pp_o;
            end
        end
    end

endmodule

// File: rtl/mul_seq_mac.sv
// Multi-cycle shift-add multiplier/MAC retiring BPC multiplier bits per cycle,
// with sign modes, optional addend, early termination and valid/ready on both sides.
module mul_seq_mac
    import mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BPC   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [2*WIDTH-1:0]   c_i,
    input  logic [1:0]           mode_i,
    input  logic                 acc_en_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 busy_o
);

    localparam int W2     = 2 * WIDTH;
    localparam int NCHUNK = mul_nchunk(WIDTH, BPC);
    localparam int CW     = mul_cnt_w(NCHUNK);
    localparam logic [CW-1:0] NCHUNK_C = CW'(NCHUNK);

    generate
        if (WIDTH < 4 || !(BPC == 1 || BPC == 2 || BPC == 4) || (WIDTH % BPC) != 0) begin : g_bad_param
            $error("mul_seq_mac: WIDTH must be >= 4 and BPC in {1,2,4} dividing WIDTH");
        end
    endgenerate

    mul_state_e       state_q, state_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    addend_q, addend_d;
    logic [W2-1:0]    result_q, result_d;
    logic [WIDTH-1:0] mreg_q, mreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [W2-1:0]    pp_s, acc_sum_s, prod_s;
    logic [WIDTH-1:0] mreg_shift_s, a_abs_s, b_abs_s;
    logic [CW-1:0]    cnt_inc_s;
    logic             a_neg_s, b_neg_s, in_ready_s, accept_s, last_s;

    mul_pp #(.WIDTH(WIDTH), .BPC(BPC)) u_pp (
        .mcand_i (mcand_q),
        .chunk_i (mreg_q[BPC-1:0]),
        .pp_o    (pp_s)
    );

    // Operand magnitudes, handshake qualifiers and the per-chunk datapath
    always_comb begin
        a_neg_s      = ((mode_i == MUL_SS) || (mode_i == MUL_SU)) && a_i[WIDTH-1];
        b_neg_s      = (mode_i == MUL_SS) && b_i[WIDTH-1];
        a_abs_s      = a_neg_s ? (-a_i) : a_i;
        b_abs_s      = b_neg_s ? (-b_i) : b_i;
        in_ready_s   = !flush_i && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i));
        accept_s     = in_valid_i && in_ready_s;
        acc_sum_s    = acc_q + pp_s;
        mreg_shift_s = mreg_q >> BPC;
        cnt_inc_s    = cnt_q + CW'(1);
        last_s       = (mreg_shift_s == '0) || (cnt_inc_s == NCHUNK_C);
        prod_s       = (neg_q ? (-acc_sum_s) : acc_sum_s) + addend_q;
    end

    // Next-state and register updates; flush overrides every state
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        addend_d    = addend_q;
        result_d    = result_q;
        mreg_d      = mreg_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        if (flush_i) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_d = ST_CALC;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_d   = acc_sum_s;
                    mcand_d = mcand_q << BPC;
                    mreg_d  = mreg_shift_s;
                    cnt_d   = cnt_inc_s;
                    if (last_s) begin
                        state_d     = ST_DONE;
                        result_d    = prod_s;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_d = 1'b0;
                        if (accept_s) begin
                            state_d = ST_CALC;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
            // accept_s is only ever true in IDLE or DONE, so loading here is safe
            if (accept_s) begin
                mcand_d  = {{WIDTH{1'b0}}, a_abs_s};
                mreg_d   = b_abs_s;
                neg_d    = a_neg_s ^ b_neg_s;
                addend_d = acc_en_i ? c_i : '0;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                neg_d = neg_q;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            addend_q    <= '0;
            result_q    <= '0;
            mreg_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            addend_q    <= addend_d;
            result_q    <= result_d;
            mreg_q      <= mreg_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mul_seq_mac.sv
// Scoreboard bench for mul_seq_mac: directed cases plus randomized traffic against an arithmetic model.
module tb_mul_seq_mac;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid_i = 1'b0;
    logic           acc_en_i = 1'b0;
    logic           flush_i = 1'b0;
    logic [W-1:0]   a_i = '0;
    logic [W-1:0]   b_i = '0;
    logic [2*W-1:0] c_i = '0;
    logic [1:0]     mode_i = 2'b00;
    logic           in_ready_o, out_valid_o, busy_o, out_ready_i;
    logic [2*W-1:0] result_o;
    logic           fixed_rdy = 1'b1;
    logic           rand_rdy = 1'b0;
    logic           rnd_rdy = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    int          acc_cyc_q[$];
    int          k_q[$];

    mul_seq_mac #(.WIDTH(W), .BPC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .c_i         (c_i),
        .mode_i      (mode_i),
        .acc_en_i    (acc_en_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    assign out_ready_i = rand_rdy ? rnd_rdy : fixed_rdy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic logic [31:0] model_res(input logic [15:0] a, input logic [15:0] b,
                                              input logic [31:0] c, input logic [1:0] m, input logic acc);
        longint av, bv, cv;
        av = (m == 2'b01 || m == 2'b10) ? longint'($signed(a)) : longint'(a);
        bv = (m == 2'b01) ? longint'($signed(b)) : longint'(b);
        cv = acc ? longint'(c) : 64'sd0;
        return 32'(av * bv + cv);
    endfunction

    function automatic int model_lat(input logic [15:0] b, input logic [1:0] m);
        int mag, bl;
        mag = (m == 2'b01 && b[15]) ? (65536 - int'(b)) : int'(b);
        bl = 0;
        while (mag > 0) begin
            bl++;
            mag = mag >> 1;
        end
        return (bl <= 2) ? 1 : (bl + 1) / 2;
    endfunction

    // Caller is at a falling edge; returns at the falling edge after the accept edge
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c,
                         input logic [1:0] m, input logic acc, input bit track);
        int waits = 0;
        in_valid_i = 1'b1; a_i = a; b_i = b; c_i = c; mode_i = m; acc_en_i = acc;
        #1;
        while (!in_ready_o && waits < 300) begin
            @(negedge clk); #1;
            waits++;
        end
        if (!in_ready_o) begin
            chk("issue_timeout", 64'(in_ready_o), 64'd1);
        end else if (track) begin
            exp_q.push_back(model_res(a, b, c, m, acc));
            acc_cyc_q.push_back(cyc + 1);
            k_q.push_back(model_lat(b, m));
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        a_i = 16'($urandom); b_i = 16'($urandom);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!out_valid_o && n < 100);
        if (!out_valid_o) chk({name, "_timeout"}, 64'(out_valid_o), 64'd1);
    endtask

    task automatic run_dir(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] c, input logic [1:0] m, input logic acc,
                           input logic [31:0] want);
        issue(a, b, c, m, acc, 1'b1);
        wait_valid(name);
        chk(name, 64'(result_o), 64'(want));
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: latency on first valid, result on each output handshake
    initial begin : monitor
        bit seen;
        logic [31:0] e;
        seen = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (out_valid_o && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) chk("spurious_valid", 64'(out_valid_o), 64'd0);
                else chk("latency", 64'(cyc - acc_cyc_q[0]), 64'(k_q[0]));
            end
            if (out_valid_o && out_ready_i && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                void'(acc_cyc_q.pop_front());
                void'(k_q.pop_front());
                chk("result", 64'(result_o), 64'(e));
                seen = 1'b0;
            end
        end
    end

    initial begin : main
        logic [31:0] held;
        logic [15:0] ra, rb;
        @(negedge clk); #1;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_dir("ss_neg21",   16'hFFFD, 16'h0007, 32'h0,        2'b01, 1'b0, 32'hFFFFFFEB);
        run_dir("ss_minmin",  16'h8000, 16'h8000, 32'h0,        2'b01, 1'b0, 32'h40000000);
        run_dir("uu_max",     16'hFFFF, 16'hFFFF, 32'h0,        2'b00, 1'b0, 32'hFFFE0001);
        run_dir("su_max",     16'hFFFF, 16'hFFFF, 32'h0,        2'b10, 1'b0, 32'hFFFF0001);
        run_dir("mode11",     16'hFFFF, 16'hFFFF, 32'h0,        2'b11, 1'b0, 32'hFFFE0001);
        run_dir("b0_acc",     16'h1234, 16'h0000, 32'h12345678, 2'b00, 1'b1, 32'h12345678);
        run_dir("acc_wrap",   16'h0005, 16'h0003, 32'hFFFFFFF0, 2'b00, 1'b1, 32'hFFFFFFFF);

        // Backpressure, then a back-to-back accept on the handshake edge
        fixed_rdy = 1'b0;
        issue(16'h0123, 16'h0456, 32'h0, 2'b00, 1'b0, 1'b1);
        wait_valid("bp");
        held = result_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_result", 64'(result_o), 64'(held));
            chk("bp_in_ready", 64'(in_ready_o), 64'd0);
        end
        @(negedge clk);
        fixed_rdy = 1'b1;
        issue(16'h0002, 16'h0003, 32'h0, 2'b00, 1'b0, 1'b1);
        #1;
        chk("b2b_busy", 64'(busy_o), 64'd1);
        wait_valid("b2b");
        chk("b2b_result", 64'(result_o), 64'h6);
        @(negedge clk);

        // Flush on the third CALC edge
        issue(16'h8000, 16'h8000, 32'h0, 2'b01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_ready", 64'(in_ready_o), 64'd1);
        chk("flush_keeps_result", 64'(result_o), 64'h6);
        repeat (10) begin
            @(negedge clk); #1;
            chk("flush_no_pulse", 64'(out_valid_o), 64'd0);
        end
        @(negedge clk);

        // Same with reset, which also clears the result
        issue(16'h8000, 16'h8000, 32'h0, 2'b01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid_o), 64'd0);
        chk("rst_mid_busy", 64'(busy_o), 64'd0);
        chk("rst_mid_result", 64'(result_o), 64'd0);
        repeat (10) begin
            @(negedge clk); #1;
            chk("rst_no_pulse", 64'(out_valid_o), 64'd0);
        end
        @(negedge clk);
        run_dir("after_rst", 16'h1234, 16'h5678, 32'h0, 2'b00, 1'b0, 32'h06260060);

        // Randomized traffic with a randomly stalling consumer
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            issue(ra, rb, 32'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        rand_rdy = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
